// File: rtl/rca_nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder.
//   - FSM state encodings (IDLE/RUN/DONE)
//   - NIBBLE_W: width of the shared ripple-carry slice
package rca_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rca_state_e;

endpackage

// File: rtl/rca_nibble_add_seq_if.sv
// Handshake bus for rca_nibble_add_seq.
//   Input side : in_valid/in_ready, in_a, in_b, in_cin
//   Output side: out_valid/out_ready, out_sum, out_cout (+ out_ovf when
//                OVERFLOW_FLAG_EN is defined), busy
//   slave  modport: the adder
//   master modport: the producer/consumer driving it
interface rca_nibble_add_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef OVERFLOW_FLAG_EN
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy, out_ovf
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy, out_ovf
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );
`endif
endinterface

// File: rtl/rca_nibble_add_seq_rca.sv
// ripple_carry_adder: combinational NIBBLE_W-bit ripple-carry adder.
//   sum   out  NIBBLE_W  a + b + cin, low bits
//   carry out  1         carry out of the top bit
//   a, b  in   NIBBLE_W  operands
//   cin   in   1         carry in
module ripple_carry_adder
  import rca_seq_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign carry = c[NIBBLE_W];

endmodule

// File: rtl/rca_nibble_add_seq.sv
// rca_nibble_add_seq: multi-cycle WIDTH-bit adder built around one shared
// 4-bit ripple-carry adder, processing one nibble per cycle, LSB first,
// with the inter-nibble carry held in a register.
//   clk    in  clock, rising edge
//   rst_n  in  synchronous active-low reset
//   bus    slave modport of rca_nibble_add_seq_if (valid/ready in and out,
//          operands, sum, carry out, busy)
// Optional feature macro: OVERFLOW_FLAG_EN adds out_ovf (two's-complement
// overflow) on the bus, registered on entry to DONE.
// WIDTH must be a multiple of 4 and >= 4; the interface WIDTH must match.
module rca_nibble_add_seq
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca_nibble_add_seq_if.slave  bus
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB   = WIDTH - 1;

  rca_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef OVERFLOW_FLAG_EN
  logic               ovf_q, ovf_d;
`endif

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_carry;
  logic                last_nib;

  // Nibble mux: select the active slice of each operand register.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IDX_W'(n)) begin
        nib_a = a_q[NIBBLE_W*n +: NIBBLE_W];
        nib_b = b_q[NIBBLE_W*n +: NIBBLE_W];
      end
    end
  end

  ripple_carry_adder u_rca (
    .sum   (nib_sum),
    .carry (nib_carry),
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_q)
  );

  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Nibble demux: write this cycle's slice back into the sum register.
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IDX_W'(n)) sum_d[NIBBLE_W*n +: NIBBLE_W] = nib_sum;
        end
        carry_d = nib_carry;
        if (last_nib) begin
          cout_d  = nib_carry;
          state_d = ST_DONE;
`ifdef OVERFLOW_FLAG_EN
          // The top nibble is being written now, so its MSB is nib_sum's MSB.
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (nib_sum[NIBBLE_W-1] != a_q[MSB]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign bus.out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_rca_nibble_add_seq.sv
// Self-checking bench for rca_nibble_add_seq (WIDTH=16). Expected results
// come from plain integer addition of the operands.
module tb_rca_nibble_add_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  rca_nibble_add_seq_if #(.WIDTH(W)) bus ();

  rca_nibble_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full (WIDTH+1)-bit sum and signed overflow.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic cin);
    int sa, sb, s;
    sa = int'(signed'(a));
    sb = int'(signed'(b));
    s  = sa + sb + int'(cin);
    return (s > 32767) || (s < -32768);
  endfunction

  // Present one operation, check latency and result, hold out_ready low for
  // `hold` cycles, then complete the handshake. All sampling at negedge.
  task automatic run_op(input string tag, input logic [W-1:0] a, b, input logic cin,
                        input int hold);
    logic [W:0] exp;
    int n;
    exp = ref_sum(a, b, cin);
    @(negedge clk);
    check({tag, ":in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a = ~a; bus.in_b = ~b;   // post-accept changes must not matter
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'(NIB));
    for (int h = 0; h <= hold; h++) begin
      check({tag, ":sum"}, 32'(bus.out_sum), 32'(exp[W-1:0]));
      check({tag, ":cout"}, 32'(bus.out_cout), 32'(exp[W]));
`ifdef OVERFLOW_FLAG_EN
      check({tag, ":ovf"}, 32'(bus.out_ovf), 32'(ref_ovf(a, b, cin)));
`endif
      check({tag, ":in_ready_done"}, 32'(bus.in_ready), 32'd0);
      check({tag, ":valid"}, 32'(bus.out_valid), 32'd1);
      if (h < hold) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ":valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, ":busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [W:0] exp;
    logic [W-1:0] ra, rb;
    logic rc;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst:in_ready", 32'(bus.in_ready), 32'd1);
    check("rst:out_valid", 32'(bus.out_valid), 32'd0);
    check("rst:busy", 32'(bus.busy), 32'd0);
    check("rst:sum", 32'(bus.out_sum), 32'd0);
    check("rst:cout", 32'(bus.out_cout), 32'd0);
    rst_n = 1'b1;

    run_op("t1", 16'h1234, 16'h0001, 1'b0, 0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1);
    run_op("t3a", 16'hFFFF, 16'hFFFF, 1'b1, 0);
    run_op("t3b", 16'h0000, 16'h0000, 1'b1, 0);
`ifdef OVERFLOW_FLAG_EN
    run_op("t6a", 16'h7FFF, 16'h0001, 1'b0, 0);
    run_op("t6b", 16'h8000, 16'h8000, 1'b0, 0);
    run_op("t6c", 16'h0001, 16'hFFFF, 1'b0, 0);
`endif

    // t4: backpressure in DONE with a new op already waiting on in_valid.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 16'h0F0F; bus.in_b = 16'h0101; bus.in_cin = 1'b0;
    @(negedge clk);
    bus.in_a = 16'h1111; bus.in_b = 16'h2222; bus.in_cin = 1'b1;  // next op, held
    repeat (NIB) @(negedge clk);
    exp = ref_sum(16'h0F0F, 16'h0101, 1'b0);
    for (int h = 0; h < 3; h++) begin
      check("t4:sum_hold", 32'(bus.out_sum), 32'(exp[W-1:0]));
      check("t4:cout_hold", 32'(bus.out_cout), 32'(exp[W]));
      check("t4:in_ready", 32'(bus.in_ready), 32'd0);
      check("t4:valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4:idle_after_hs", 32'(bus.in_ready), 32'd1);
    check("t4:busy_after_hs", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t4:accepted_next", 32'(bus.busy), 32'd1);
    repeat (NIB) @(negedge clk);
    exp = ref_sum(16'h1111, 16'h2222, 1'b1);
    check("t4:next_valid", 32'(bus.out_valid), 32'd1);
    check("t4:next_sum", 32'(bus.out_sum), 32'(exp[W-1:0]));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // t5: reset while RUN has reached idx=2.
    bus.in_valid = 1'b1; bus.in_a = 16'hABCD; bus.in_b = 16'h1234; bus.in_cin = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5:in_ready", 32'(bus.in_ready), 32'd1);
    check("t5:out_valid", 32'(bus.out_valid), 32'd0);
    check("t5:busy", 32'(bus.busy), 32'd0);
    check("t5:sum_cleared", 32'(bus.out_sum), 32'd0);
    run_op("t5b", 16'h00FF, 16'h0001, 1'b0, 0);

    // Random operations with random backpressure.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op("rnd", ra, rb, rc, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
